// File: rtl/instruction_encoder.sv
// Registered RV32I encoder: packs I/S/B/U/J words and expands li into LUI+ADDI.
// One-cycle latency; valid/ready on both sides, input stalls while an output word is held.
module instruction_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ins,
  output logic        out_last,
  output logic        range_err
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_U  = 3'd3;
  localparam logic [2:0] FMT_J  = 3'd4;
  localparam logic [2:0] FMT_LI = 3'd5;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
  localparam logic [31:0] INS_NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT     = 2'd1,
    EMIT_LI1 = 2'd2
  } state_t;

  state_t state, state_next;

  logic        accept;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        enc_two;
  logic [19:0] li_hi;
  logic        fits_12, fits_13, fits_21;

  logic [31:0] ins_q;
  logic        last_q;
  logic        err_q;
  logic [4:0]  li_rd_q;
  logic [11:0] li_lo_q;

  assign in_ready = !reset && (state == IDLE || (state == EMIT && out_ready));
  assign accept   = in_valid && in_ready;

  // A value fits in N signed bits when bits [31:N-1] are all copies of the sign.
  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  // Upper part rounded so that the sign-extended ADDI immediate lands on imm.
  assign li_hi = imm[31:12] + {19'd0, imm[11]};

  always_comb begin
    enc_word = INS_NOP;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (fmt)
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = !fits_12;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = !fits_12;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = !fits_13 || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = |imm[11:0];
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = !fits_21 || imm[0];
      end
      FMT_LI: begin
        if (li_hi != 20'd0) begin
          enc_word = {li_hi, rd, OP_LUI};
          enc_two  = 1'b1;
        end else begin
          enc_word = {imm[11:0], 5'd0, 3'b000, rd, OP_OPIMM};
        end
      end
      default: begin
        enc_word = INS_NOP;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = enc_two ? EMIT_LI1 : EMIT;
      end
      EMIT: begin
        if (accept)         state_next = enc_two ? EMIT_LI1 : EMIT;
        else if (out_ready) state_next = IDLE;
      end
      EMIT_LI1: begin
        if (out_ready) state_next = EMIT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ins_q   <= 32'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      li_rd_q <= 5'd0;
      li_lo_q <= 12'd0;
    end else if (accept) begin
      ins_q   <= enc_word;
      last_q  <= !enc_two;
      err_q   <= enc_err;
      li_rd_q <= rd;
      li_lo_q <= imm[11:0];
    end else if (state == EMIT_LI1 && out_ready) begin
      ins_q  <= {li_lo_q, li_rd_q, 3'b000, li_rd_q, OP_OPIMM};
      last_q <= 1'b1;
      err_q  <= 1'b0;
    end
  end

  assign out_valid = (state != IDLE);
  assign ins       = ins_q;
  assign out_last  = last_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vectors, backpressure, reset, and a
// randomized run scored against an arithmetic reference model.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ins;
  logic        out_last;
  logic        range_err;

  int passed = 0;
  int total  = 0;

  logic [31:0] got_ins  [4];
  logic        got_last [4];
  logic        got_err  [4];
  logic        got_rdy  [4];
  int          got_n;
  logic        got_first;

  instruction_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .ins(ins),
    .out_last(out_last), .range_err(range_err)
  );

  always #5 clk = ~clk;

  // Reference: words of a request, from the plain encoding and range rules.
  function automatic void model(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] im, output int n, output logic [31:0] w0,
                                output logic [31:0] w1, output logic e0);
    int s;
    logic [31:0] hi;
    logic [11:0] lo;
    s  = $signed(im);
    n  = 1;
    w1 = 32'd0;
    e0 = 1'b0;
    case (f)
      3'd0: begin w0 = {im[11:0], s1, f3, d, op}; e0 = (s < -2048) || (s > 2047); end
      3'd1: begin w0 = {im[11:5], s2, s1, f3, im[4:0], op}; e0 = (s < -2048) || (s > 2047); end
      3'd2: begin
        w0 = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e0 = (s < -4096) || (s > 4094) || (s % 2 != 0);
      end
      3'd3: begin w0 = {im[31:12], d, op}; e0 = (im % 4096) != 0; end
      3'd4: begin
        w0 = {im[20], im[10:1], im[11], im[19:12], d, op};
        e0 = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      end
      3'd5: begin
        hi = (im + 32'h800) / 4096;
        lo = im[11:0];
        if (hi != 0) begin
          n  = 2;
          w0 = {hi[19:0], d, 7'h37};
          w1 = {lo, d, 3'b000, d, 7'h13};
        end else begin
          w0 = {lo, 5'd0, 3'b000, d, 7'h13};
        end
      end
      default: begin w0 = 32'h13; e0 = 1'b1; end
    endcase
  endfunction

  // Issue one request with out_ready high and record every output word.
  task automatic do_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im);
    int n;
    @(negedge clk);
    fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid  = 1'b0;
    got_n     = 0;
    got_first = out_valid;
    n = 0;
    while (n < 6) begin
      if (out_valid && got_n < 4) begin
        got_ins[got_n]  = ins;
        got_last[got_n] = out_last;
        got_err[got_n]  = range_err;
        got_rdy[got_n]  = in_ready;
        got_n++;
        if (out_last) break;
      end
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || ins !== 32'd0 || out_last !== 1'b0 || range_err !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL reset: valid=%b ins=%h last=%b err=%b rdy=%b, want 0 0 0 0 0",
               out_valid, ins, out_last, range_err, in_ready);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_formats;
    do_req(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    total++;
    if (got_first !== 1'b1 || got_n != 1 || got_ins[0] !== 32'hFFF0_0093 || got_err[0] !== 1'b0 || got_last[0] !== 1'b1)
      $display("FAIL i_fmt: first=%b n=%0d ins=%h err=%b last=%b, want 1 1 fff00093 0 1",
               got_first, got_n, got_ins[0], got_err[0], got_last[0]);
    else passed++;

    do_req(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    total++;
    if (got_n != 1 || got_ins[0] !== 32'hFE20_8EE3 || got_err[0] !== 1'b0)
      $display("FAIL b_fmt: n=%0d ins=%h err=%b, want 1 fe208ee3 0", got_n, got_ins[0], got_err[0]);
    else passed++;

    do_req(3'd2, 7'h63, 3'd1, 5'd0, 5'd3, 5'd4, 32'd4094);
    total++;
    if (got_err[0] !== 1'b0) $display("FAIL b_max: err=%b want 0", got_err[0]);
    else passed++;

    do_req(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000);
    total++;
    if (got_ins[0] !== 32'h8000_00EF || got_err[0] !== 1'b0)
      $display("FAIL j_min: ins=%h err=%b, want 800000ef 0", got_ins[0], got_err[0]);
    else passed++;

    do_req(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1048576);
    total++;
    if (got_err[0] !== 1'b1) $display("FAIL j_over: err=%b want 1", got_err[0]);
    else passed++;
  endtask

  task automatic test_li;
    do_req(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    total++;
    if (got_n != 2 || got_ins[0] !== 32'h1234_62B7 || got_last[0] !== 1'b0 || got_rdy[0] !== 1'b0 ||
        got_ins[1] !== 32'hFFF2_8293 || got_last[1] !== 1'b1 || got_err[0] !== 1'b0 || got_err[1] !== 1'b0)
      $display("FAIL li_two: n=%0d w0=%h l0=%b rdy0=%b w1=%h l1=%b, want 2 123462b7 0 0 fff28293 1",
               got_n, got_ins[0], got_last[0], got_rdy[0], got_ins[1], got_last[1]);
    else passed++;

    do_req(3'd5, 7'h00, 3'd0, 5'd3, 5'd0, 5'd0, 32'h0000_07FF);
    total++;
    if (got_n != 1 || got_ins[0] !== 32'h7FF0_0193 || got_last[0] !== 1'b1)
      $display("FAIL li_one: n=%0d ins=%h last=%b, want 1 7ff00193 1", got_n, got_ins[0], got_last[0]);
    else passed++;
  endtask

  task automatic test_range_errors;
    logic [31:0] w;
    do_req(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    w = got_ins[0];
    total++;
    if (got_err[0] !== 1'b1 || w[31:20] !== 12'h800)
      $display("FAIL i_range: err=%b imm_field=%h, want 1 800", got_err[0], w[31:20]);
    else passed++;

    do_req(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    total++;
    if (got_err[0] !== 1'b1) $display("FAIL b_odd: err=%b want 1", got_err[0]);
    else passed++;

    do_req(3'd3, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5001);
    total++;
    if (got_err[0] !== 1'b1 || got_ins[0] !== 32'h1234_50B7)
      $display("FAIL u_low: err=%b ins=%h, want 1 123450b7", got_err[0], got_ins[0]);
    else passed++;

    do_req(3'd7, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    total++;
    if (got_err[0] !== 1'b1 || got_ins[0] !== 32'h0000_0013 || got_last[0] !== 1'b1)
      $display("FAIL bad_fmt: err=%b ins=%h last=%b, want 1 00000013 1", got_err[0], got_ins[0], got_last[0]);
    else passed++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    fmt = 3'd5; rd = 5'd5; imm = 32'h1234_5FFF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || ins !== 32'h1234_62B7 || out_last !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: valid=%b ins=%h last=%b rdy=%b, want 1 123462b7 0 0",
                 i, out_valid, ins, out_last, in_ready);
      else passed++;
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || ins !== 32'hFFF2_8293 || out_last !== 1'b1)
      $display("FAIL bp_second: valid=%b ins=%h last=%b, want 1 fff28293 1", out_valid, ins, out_last);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain: valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_li;
    logic seen;
    @(negedge clk);
    fmt = 3'd5; rd = 5'd7; imm = 32'hDEAD_BEEF; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_last !== 1'b0)
      $display("FAIL rst_li_setup: valid=%b last=%b, want 1 0", out_valid, out_last);
    else passed++;
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rst_li_flush: valid=%b rdy=%b, want 0 0", out_valid, in_ready);
    else passed++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rst_li_dropped: second word seen=%b want 0", seen);
    else passed++;
  endtask

  task automatic test_random;
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic [31:0] w0, w1, prev_ins;
    logic        e0, prev_hold, prev_last, prev_err;
    int          n, issued, cyc;
    issued = 0; prev_hold = 1'b0; prev_ins = 32'd0; prev_last = 1'b0; prev_err = 1'b0;
    cyc = 0;
    while (cyc < 6000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (issued < 400) begin
        in_valid = $urandom_range(0, 1);
        fmt = $urandom_range(0, 7);
        opcode = $urandom; funct3 = $urandom; rd = $urandom; rs1 = $urandom; rs2 = $urandom;
        case ($urandom_range(0, 3))
          0: imm = $urandom;
          1: imm = $urandom_range(0, 10000) - 5000;
          2: imm = $urandom & 32'hFFFF_F000;
          default: imm = $urandom_range(0, 2300000) - 1150000;
        endcase
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_hold) begin
        total++;
        if (out_valid !== 1'b1 || ins !== prev_ins || out_last !== prev_last || range_err !== prev_err)
          $display("FAIL rnd_stable: valid=%b ins=%h last=%b err=%b, want 1 %h %b %b",
                   out_valid, ins, out_last, range_err, prev_ins, prev_last, prev_err);
        else passed++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_extra: unexpected word %h", ins);
        end else begin
          e = exp_q.pop_front();
          if ({ins, out_last, range_err} !== e)
            $display("FAIL rnd_word: ins=%h last=%b err=%b, want %h %b %b",
                     ins, out_last, range_err, e[33:2], e[1], e[0]);
          else passed++;
        end
      end
      if (in_valid && in_ready) begin
        model(fmt, opcode, funct3, rd, rs1, rs2, imm, n, w0, w1, e0);
        exp_q.push_back({w0, (n == 1), e0});
        if (n == 2) exp_q.push_back({w1, 1'b1, 1'b0});
        issued++;
      end
      prev_hold = out_valid && !out_ready;
      prev_ins = ins; prev_last = out_last; prev_err = range_err;
      cyc++;
      if (issued >= 400 && exp_q.size() == 0 && !out_valid) break;
    end
    total++;
    if (issued != 400 || exp_q.size() != 0)
      $display("FAIL rnd_complete: issued=%0d pending=%0d, want 400 0", issued, exp_q.size());
    else passed++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_formats;
    test_li;
    test_range_errors;
    test_backpressure;
    test_reset_mid_li;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
